// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
// Optional SYSTEM/CSR decode is enabled by defining IMMGEN_CSR_EN.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_Z   = 3'd6,
        FMT_ILL = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> sign-extended immediate,
// format code and illegal flag. With IMMGEN_CSR_EN defined, SYSTEM opcodes decode
// to FMT_Z (CSR zimm) or FMT_I; otherwise SYSTEM is treated as illegal.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    // Every immediate is first assembled as a 32-bit value whose bit 31 carries
    // the sign; widening to XLEN is then a single sign extension.
    logic [31:0] imm32;

    // Select format and assemble the raw immediate from the opcode field.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        imm32   = '0;
        fmt     = FMT_ILL;
        illegal = 1'b1;
        case (inst[6:0])
            OPC_OP: begin
                fmt     = FMT_R;
                illegal = 1'b0;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt     = FMT_I;
                illegal = 1'b0;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                fmt     = FMT_S;
                illegal = 1'b0;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt     = FMT_B;
                illegal = 1'b0;
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt     = FMT_U;
                illegal = 1'b0;
                imm32   = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt     = FMT_J;
                illegal = 1'b0;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
`ifdef IMMGEN_CSR_EN
            OPC_SYSTEM: begin
                illegal = 1'b0;
                if (inst[14:12] inside {3'b101, 3'b110, 3'b111}) begin
                    // zimm is unsigned; bit 31 stays 0 so the sign extension below zero-fills
                    fmt   = FMT_Z;
                    imm32 = {27'b0, inst[19:15]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
`endif
            default: begin
                // Unlisted opcodes, including any with inst[1:0] != 2'b11, stay FMT_ILL.
                fmt     = FMT_ILL;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// One-stage registered RISC-V immediate generator with valid/ready on both sides,
// flush, and a saturating count of accepted illegal instructions.
// Optional SYSTEM/CSR decode in imm_decode is enabled by defining IMMGEN_CSR_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output imm_fmt_e         fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_cnt
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    imm_fmt_e         fmt_q,       fmt_d;
    logic             illegal_q,   illegal_d;
    logic [CNT_W-1:0] ill_cnt_q,   ill_cnt_d;
    logic             accept;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // The stage can take a new word when empty or when its current word leaves this cycle.
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state for the output register and the saturating illegal counter.
    always_comb begin
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        fmt_d       = fmt_q;
        illegal_d   = illegal_q;
        ill_cnt_d   = ill_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            imm_d       = dec_imm;
            fmt_d       = dec_fmt;
            illegal_d   = dec_illegal;
            if (dec_illegal && (ill_cnt_q != '1)) begin
                ill_cnt_d = ill_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held entry and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            fmt_q       <= FMT_R;
            illegal_q   <= 1'b0;
            ill_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign illegal   = illegal_q;
    assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. Two instances share one input stream:
// dut_a (XLEN=32, CNT_W=2) and dut_b (XLEN=64, CNT_W=8).
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    imm_fmt_e    fmt_a;
    logic [1:0]  ill_cnt_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    imm_fmt_e    fmt_b;
    logic [7:0]  ill_cnt_b;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .inst(inst),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .imm(imm_a), .fmt(fmt_a), .illegal(illegal_a), .ill_cnt(ill_cnt_a)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .inst(inst),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .imm(imm_b), .fmt(fmt_b), .illegal(illegal_b), .ill_cnt(ill_cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm64;
        imm_fmt_e    fmt;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fails = 0;

    // Protocol model state kept by the driver.
    logic mdl_valid;
    int   mdl_cnt_a;
    int   mdl_cnt_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Interpret a bit field of the given width as two's complement.
    function automatic longint sx(input longint field, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (field >= half) ? field - (longint'(1) << bits) : field;
    endfunction

    // Reference decode written from the instruction-format rules with arithmetic.
    function automatic exp_t ref_model(input logic [31:0] i);
        exp_t   e;
        longint v = 0;
        e.fmt = FMT_ILL;
        e.ill = 1'b1;
        if (i[6:0] == OPC_OP) begin
            e.fmt = FMT_R; e.ill = 1'b0; v = 0;
        end else if (i[6:0] == OPC_OP_IMM || i[6:0] == OPC_LOAD || i[6:0] == OPC_JALR) begin
            e.fmt = FMT_I; e.ill = 1'b0;
            v = sx(longint'(i[31:20]), 12);
        end else if (i[6:0] == OPC_STORE) begin
            e.fmt = FMT_S; e.ill = 1'b0;
            v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
        end else if (i[6:0] == OPC_BRANCH) begin
            e.fmt = FMT_B; e.ill = 1'b0;
            v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                   + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
        end else if (i[6:0] == OPC_LUI || i[6:0] == OPC_AUIPC) begin
            e.fmt = FMT_U; e.ill = 1'b0;
            v = sx(longint'(i[31:12]), 20) * 4096;
        end else if (i[6:0] == OPC_JAL) begin
            e.fmt = FMT_J; e.ill = 1'b0;
            v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                   + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
        end
`ifdef IMMGEN_CSR_EN
        else if (i[6:0] == OPC_SYSTEM) begin
            e.ill = 1'b0;
            if (i[14:12] >= 3'd5) begin
                e.fmt = FMT_Z; v = longint'(i[19:15]);
            end else begin
                e.fmt = FMT_I; v = sx(longint'(i[31:20]), 12);
            end
        end
`endif
        e.imm64 = 64'(v);
        return e;
    endfunction

    // Drive one cycle of inputs, check protocol-level outputs, update the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        logic exp_rdy;
        logic acc;
        exp_t e;
        in_valid  = v;
        inst      = ins;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        exp_rdy = !fl && (!mdl_valid || ordy);
        check("in_ready_a", 64'(in_ready_a), 64'(exp_rdy));
        check("in_ready_b", 64'(in_ready_b), 64'(exp_rdy));
        check("out_valid_a", 64'(out_valid_a), 64'(mdl_valid));
        check("out_valid_b", 64'(out_valid_b), 64'(mdl_valid));
        check("ill_cnt_a", 64'(ill_cnt_a), 64'(mdl_cnt_a));
        check("ill_cnt_b", 64'(ill_cnt_b), 64'(mdl_cnt_b));
        acc = v && exp_rdy;
        if (acc) begin
            e = ref_model(ins);
            exp_q.push_back(e);
            if (e.ill) begin
                if (mdl_cnt_a < 3)   mdl_cnt_a++;
                if (mdl_cnt_b < 255) mdl_cnt_b++;
            end
        end
        if (fl)        mdl_valid = 1'b0;
        else if (acc)  mdl_valid = 1'b1;
        else if (ordy) mdl_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented output against the scoreboard head every cycle it is valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_a) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid_a), 64'(0));
            end else begin
                e = exp_q[0];
                check("imm_a", 64'(imm_a), 64'(e.imm64[31:0]));
                check("imm_b", imm_b, e.imm64);
                check("fmt_a", 64'(fmt_a), 64'(e.fmt));
                check("fmt_b", 64'(fmt_b), 64'(e.fmt));
                check("illegal_a", 64'(illegal_a), 64'(e.ill));
                check("illegal_b", 64'(illegal_b), 64'(e.ill));
                if (flush || out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic apply_reset_mid();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid_a", 64'(out_valid_a), 64'(0));
        check("rst_out_valid_b", 64'(out_valid_b), 64'(0));
        check("rst_ill_cnt_a", 64'(ill_cnt_a), 64'(0));
        check("rst_ill_cnt_b", 64'(ill_cnt_b), 64'(0));
        exp_q.delete();
        mdl_valid = 1'b0;
        mdl_cnt_a = 0;
        mdl_cnt_b = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b[5];
        logic [6:0]  opcs[12];
        logic [31:0] r;
        b2b  = '{32'hfffb8b93, 32'h0082a223, 32'h014c6463, 32'h7ff080e7, 32'h0000006f};
        opcs = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
                 OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, 7'b1111111, 7'b0010010};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0;
        mdl_valid = 1'b0; mdl_cnt_a = 0; mdl_cnt_b = 0;
        #2;
        check("reset_out_valid", 64'(out_valid_a), 64'(0));
        check("reset_imm_a", 64'(imm_a), 64'(0));
        check("reset_imm_b", imm_b, 64'(0));
        check("reset_fmt", 64'(fmt_a), 64'(FMT_R));
        check("reset_illegal", 64'(illegal_a), 64'(0));
        check("reset_ill_cnt", 64'(ill_cnt_a), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back at full throughput.
        foreach (b2b[k]) cycle(1'b1, b2b[k], 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Upper immediates at both widths.
        cycle(1'b1, 32'h872370b7, 1'b1, 1'b0);
        cycle(1'b1, 32'h10000917, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: hold three cycles, then release and accept in the same cycle.
        cycle(1'b1, 32'h01190933, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 32'h00a00093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00a00093, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a held output and an illegal word presented.
        cycle(1'b1, 32'h00500113, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000007f, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Saturating illegal counter, then reset while a word is in flight.
        repeat (5) cycle(1'b1, 32'h0000007f, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000007f, 1'b0, 1'b0);
        apply_reset_mid();

        // SYSTEM words; expectation depends on IMMGEN_CSR_EN.
        cycle(1'b1, 32'h34202573, 1'b1, 1'b0);
        cycle(1'b1, 32'h0002d073, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            cycle($urandom_range(0, 3) != 0,
                  {r[31:7], opcs[$urandom_range(0, 11)]},
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end

        // Drain.
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
